dmem_store_buffer: RTL and testbench

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

---
 rtl/riscv_mem_pkg.sv | 71 +++++++
 rtl/sb_fifo.sv | 53 +++++
 rtl/dmem_store_buffer.sv | 143 ++++++++++++++
 tb/tb_dmem_store_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions for the data-memory store buffer.
// Holds funct3 encodings, FSM states, FIFO entry layout and lane helpers.
// Pure definitions; no timing or flow-control behaviour of its own.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_LD_REQ,
    ST_LD_RESP
  } mem_state_t;

  typedef struct packed {
    logic [29:0] waddr;  // word address, byte offset dropped
    logic [31:0] data;   // already replicated into the target lanes
    logic [3:0]  be;
  } sb_entry_t;

  // Halfwords need even addresses, words need word-aligned addresses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: is_misaligned = lo[0];
      F3_W:        is_misaligned = (lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    store_be = 4'b0001 << lo;
      F3_H:    store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'hF;
    endcase
  endfunction

  // Replicating the datum into every lane lets the byte enables pick the lane.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    store_wdata = {4{d[7:0]}};
      F3_H:    store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'h0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'h0, h};
      default: load_ext = rdata;
    endcase
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue of DEPTH entries with occupancy count.
// Latency 1: a pushed entry is visible at the head the following cycle.
// Push ignored when full, pop ignored when empty; caller checks full/empty.
module sb_fifo
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  sb_entry_t              push_entry,
  input  logic                   pop,
  output sb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer with blocking loads that drain pending stores first.
// Latency 1 from store enqueue to bus request; loads finish one cycle after bus_ready.
// Stalls the CPU on a full queue or during a load; bus fields hold until bus_ready.
module dmem_store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [2:0]             st_funct3,
  input  logic                   ld_req,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_funct3,
  output logic [31:0]            ld_data,
  output logic                   ld_done,
  output logic                   stall,
  output logic                   misalign,
  output logic [$clog2(DEPTH):0] count,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_wdata,
  output logic [3:0]             bus_be,
  input  logic                   bus_ready,
  input  logic [31:0]            bus_rdata
);

  mem_state_t state, state_nxt;
  sb_entry_t  head, push_entry;
  logic       full, empty;
  logic       in_idle, st_mis, ld_mis;
  logic       push, pop, st_full_stall, st_drop, ld_take, ld_drop;
  logic [31:0] ld_addr_q;
  logic [2:0]  ld_f3_q;
  logic [31:0] ld_data_q;
  logic        misalign_q;

  // Store lane formatting happens once, at enqueue, so the head drives the bus directly.
  assign push_entry = '{waddr: st_addr[31:2],
                        data:  store_wdata(st_funct3, st_data),
                        be:    store_be(st_funct3, st_addr[1:0])};

  assign in_idle       = (state == ST_IDLE);
  assign st_mis        = is_misaligned(st_funct3, st_addr[1:0]);
  assign ld_mis        = is_misaligned(ld_funct3, ld_addr[1:0]);
  // The store is resolved before a same-cycle load; a dequeue this cycle does not free a slot.
  assign st_full_stall = in_idle & st_valid & full;
  assign st_drop       = in_idle & st_valid & ~full & st_mis;
  assign push          = in_idle & st_valid & ~full & ~st_mis;
  assign ld_take       = in_idle & ld_req;
  assign ld_drop       = ld_take & ld_mis;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Bus mux: the load read owns the bus in LD_REQ, otherwise the queue head drains.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    if (state == ST_LD_REQ) begin
      bus_req  = 1'b1;
      bus_addr = {ld_addr_q[31:2], 2'b00};
      bus_be   = 4'hF;
    end else if (!empty) begin
      bus_req   = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = {head.waddr, 2'b00};
      bus_wdata = head.data;
      bus_be    = head.be;
    end
  end

  assign pop = bus_req & bus_we & bus_ready;

  // Load sequencing; misaligned loads skip the bus and complete with zero data.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ld_take) begin
          if (ld_mis)              state_nxt = ST_LD_RESP;
          else if (!empty || push) state_nxt = ST_DRAIN;
          else                     state_nxt = ST_LD_REQ;
        end
      end
      ST_DRAIN:   if (empty) state_nxt = ST_LD_REQ;
      ST_LD_REQ:  if (bus_ready) state_nxt = ST_LD_RESP;
      ST_LD_RESP: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the load request, form its result and register the misalign pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_addr_q  <= '0;
      ld_f3_q    <= '0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= st_drop | ld_drop;
      if (ld_take) begin
        ld_addr_q <= ld_addr;
        ld_f3_q   <= ld_funct3;
      end
      if (ld_drop)
        ld_data_q <= '0;
      else if (state == ST_LD_REQ && bus_ready)
        ld_data_q <= load_ext(ld_f3_q, ld_addr_q[1:0], bus_rdata);
    end
  end

  // Stall is gated by reset so the pipeline is released the instant reset asserts.
  assign stall = reset & (st_full_stall | ld_take |
                          (state == ST_DRAIN) | (state == ST_LD_REQ));

  assign ld_done  = (state == ST_LD_RESP);
  assign ld_data  = ld_data_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_data;
  logic        ld_done, stall, misalign;
  logic [2:0]  count;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_data(ld_data), .ld_done(ld_done), .stall(stall), .misalign(misalign), .count(count),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_exp_t;

  st_exp_t     exp_st[$];
  logic [31:0] exp_ld[$];
  int total = 0;
  int bad   = 0;
  int mis_seen = 0;
  int mis_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares every completed bus write and load result.
  always @(negedge clk) begin
    if (reset && bus_req && bus_we && bus_ready) begin
      if (exp_st.size() == 0) begin
        total++; bad++;
        $display("FAIL st_unexpected: got write to 0x%08h, none expected", bus_addr);
      end else begin
        st_exp_t e;
        e = exp_st.pop_front();
        check("st_addr", bus_addr, e.addr);
        check("st_wdata", bus_wdata, e.wdata);
        check("st_be", 32'(bus_be), 32'(e.be));
      end
    end
    if (ld_done) begin
      if (exp_ld.size() == 0) begin
        total++; bad++;
        $display("FAIL ld_unexpected: got ld_done data 0x%08h, none expected", ld_data);
      end else begin
        logic [31:0] x;
        x = exp_ld.pop_front();
        check("ld_data", ld_data, x);
      end
    end
    if (misalign) mis_seen++;
  end

  task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    exp_st.push_back('{ea, ew, eb});
  endtask

  task automatic start_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                            input logic [31:0] ex, input bit mis);
    ld_req = 1'b1; ld_addr = a; ld_funct3 = f3; bus_rdata = rd;
    exp_ld.push_back(ex);
    if (mis) mis_exp++;
  endtask

  // Hold ld_req (CPU frozen) until ld_done, then release it as the CPU would.
  task automatic finish_load(input string name, input logic [31:0] a);
    int n = 0;
    bit seen = 0;
    tick();
    bus_ready = 1'b1;
    while (n < 40) begin
      mid();
      if (ld_done) begin seen = 1; break; end
      if (bus_req && !bus_we) check({name, "_rdaddr"}, bus_addr, {a[31:2], 2'b00});
      tick();
      n++;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_count_at_done"}, 32'(count), 32'd0);
    check({name, "_stall_at_done"}, 32'(stall), 32'd0);
    tick();
    ld_req = 1'b0;
    mid();
    check({name, "_done_pulse"}, 32'(ld_done), 32'd0);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    mid();
    while (count != 0 && n < 50) begin
      mid();
      n++;
    end
    check(name, 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_req = 1'b0; ld_addr = '0; ld_funct3 = '0; bus_ready = 1'b0; bus_rdata = '0;

    // Reset state
    mid();
    check("rst_count", 32'(count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    tick();
    reset = 1'b1;
    bus_ready = 1'b1;

    // SB to 0x103: byte lane 3, replicated data, head on the bus one cycle later
    tick();
    issue_store(32'h103, 32'h0000_00AB, 3'b000, 32'h100, 32'hABAB_ABAB, 4'b1000);
    mid();
    check("sb_stall", 32'(stall), 32'd0);
    check("sb_bus_req_early", 32'(bus_req), 32'd0);
    tick();
    st_valid = 1'b0;
    mid();
    check("sb_bus_req", 32'(bus_req), 32'd1);
    check("sb_bus_we", 32'(bus_we), 32'd1);
    check("sb_bus_addr", bus_addr, 32'h100);
    check("sb_bus_be", 32'(bus_be), 32'b1000);
    check("sb_bus_wdata", bus_wdata, 32'hABAB_ABAB);
    wait_empty("sb_drain");

    // Back-to-back stores of each width
    tick(); issue_store(32'h206, 32'h1234_CDEF, 3'b001, 32'h204, 32'hCDEF_CDEF, 4'b1100);
    tick(); issue_store(32'h30C, 32'hDEAD_BEEF, 3'b010, 32'h30C, 32'hDEAD_BEEF, 4'b1111);
    tick(); issue_store(32'h001, 32'h0000_0055, 3'b000, 32'h000, 32'h5555_5555, 4'b0010);
    tick(); issue_store(32'h010, 32'h0000_9876, 3'b001, 32'h010, 32'h9876_9876, 4'b0011);
    tick(); st_valid = 1'b0;
    wait_empty("mix_drain");

    // Fill to DEPTH with the bus blocked; fifth store stalls until a slot frees
    tick();
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_store(32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010,
                  32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      tick();
    end
    issue_store(32'h410, 32'hA000_0004, 3'b010, 32'h410, 32'hA000_0004, 4'hF);
    mid();
    check("full_count", 32'(count), 32'd4);
    check("full_stall", 32'(stall), 32'd1);
    tick();
    mid();
    check("full_stall_hold", 32'(stall), 32'd1);
    check("full_count_hold", 32'(count), 32'd4);
    tick();
    bus_ready = 1'b1;
    mid();
    check("full_stall_same_deq", 32'(stall), 32'd1);
    tick();
    bus_ready = 1'b0;
    mid();
    check("full_count_after_deq", 32'(count), 32'd3);
    check("full_stall_released", 32'(stall), 32'd0);
    tick();
    st_valid = 1'b0;
    mid();
    check("full_count_refill", 32'(count), 32'd4);
    tick();
    bus_ready = 1'b1;
    wait_empty("full_drain");

    // Two queued stores then LB 0x201: drain first, then sign-extended byte 1
    tick();
    bus_ready = 1'b0;
    issue_store(32'h500, 32'h1111_1111, 3'b010, 32'h500, 32'h1111_1111, 4'hF);
    tick();
    issue_store(32'h505, 32'h0000_0022, 3'b000, 32'h504, 32'h2222_2222, 4'b0010);
    tick();
    st_valid = 1'b0;
    start_load(32'h201, LB, 32'h0000_8000, 32'hFFFF_FF80, 0);
    mid();
    check("ld_stall_req_cycle", 32'(stall), 32'd1);
    check("ld_count_before", 32'(count), 32'd2);
    finish_load("lb_drain", 32'h201);

    // Misaligned SH: dropped, pulse, nothing on the bus
    tick();
    st_valid = 1'b1; st_addr = 32'h3; st_data = 32'h1234; st_funct3 = 3'b001;
    mis_exp++;
    mid();
    check("mis_st_stall", 32'(stall), 32'd0);
    tick();
    st_valid = 1'b0;
    mid();
    check("mis_st_pulse", 32'(misalign), 32'd1);
    check("mis_st_count", 32'(count), 32'd0);
    check("mis_st_bus_req", 32'(bus_req), 32'd0);
    tick();
    mid();
    check("mis_st_pulse_end", 32'(misalign), 32'd0);

    // Load extension table, including a dropped misaligned LW
    tick(); start_load(32'h002, LW,  32'h1234_5678, 32'h0000_0000, 1); finish_load("lw_mis", 32'h002);
    tick(); start_load(32'h602, LH,  32'h8001_0000, 32'hFFFF_8001, 0); finish_load("lh_hi", 32'h602);
    tick(); start_load(32'h602, LHU, 32'h8001_0000, 32'h0000_8001, 0); finish_load("lhu_hi", 32'h602);
    tick(); start_load(32'h603, LBU, 32'hF000_0000, 32'h0000_00F0, 0); finish_load("lbu_b3", 32'h603);
    tick(); start_load(32'h600, LB,  32'h0000_007F, 32'h0000_007F, 0); finish_load("lb_pos", 32'h600);
    tick(); start_load(32'h604, LW,  32'hCAFE_F00D, 32'hCAFE_F00D, 0); finish_load("lw", 32'h604);

    // Store and load together: store accepted, load drains it; then reset mid-load
    tick();
    bus_ready = 1'b0;
    st_valid = 1'b1; st_addr = 32'h800; st_data = 32'h1; st_funct3 = 3'b010;
    ld_req = 1'b1; ld_addr = 32'h700; ld_funct3 = LW;
    mid();
    check("both_stall", 32'(stall), 32'd1);
    tick();
    st_valid = 1'b0;
    mid();
    check("both_count", 32'(count), 32'd1);
    check("both_stall_drain", 32'(stall), 32'd1);
    check("both_bus_req", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_bus_req", 32'(bus_req), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_ld_done", 32'(ld_done), 32'd0);
    ld_req = 1'b0;
    bus_ready = 1'b1;
    tick();
    reset = 1'b1;
    mid();
    check("post_rst_bus_req", 32'(bus_req), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);
    tick();
    mid();
    check("post_rst_idle_bus", 32'(bus_req), 32'd0);
    tick();
    issue_store(32'h0C2, 32'h0000_BEEF, 3'b001, 32'h0C0, 32'hBEEF_BEEF, 4'b1100);
    tick();
    st_valid = 1'b0;
    wait_empty("post_rst_drain");

    repeat (3) tick();
    check("st_queue_left", 32'(exp_st.size()), 32'd0);
    check("ld_queue_left", 32'(exp_ld.size()), 32'd0);
    check("misalign_pulses", 32'(mis_seen), 32'(mis_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
